// File: rtl/uart_receiver_pkg.sv
// Shared definitions for the 8N1 UART receive path: state encoding, frame constants
// and a bit-width helper used for parameter arithmetic.
package uart_receiver_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_e;

    // Number of bits needed to represent v (0 for v == 0).
    function automatic int nbits(input longint v);
        int n;
        n = 0;
        while ((v >> n) != 0) n++;
        return n;
    endfunction

endpackage

// File: rtl/uart_receiver_os_tick_gen.sv
// Free-running oversample tick at Baud*Oversampling from a fractional phase accumulator.
// Tick is the accumulator carry, so it is a one-clock pulse on every wrap.
module uart_receiver_os_tick_gen
    import uart_receiver_pkg::*;
#(
    parameter int ClkFrequency = 12000000,
    parameter int Baud         = 115200,
    parameter int Oversampling = 8
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam longint RATE      = longint'(Baud) * longint'(Oversampling);
    localparam longint CLK_F     = longint'(ClkFrequency);
    localparam int     ACC_W     = nbits(CLK_F / longint'(Baud)) + 8;
    // Pre-shift keeps RATE << (ACC_W - SHIFT_LIM) inside 32 bits before the divide.
    localparam int     SHIFT_LIM = nbits(RATE >> (31 - ACC_W));
    localparam longint INC       = ((RATE << (ACC_W - SHIFT_LIM)) + (CLK_F >> (SHIFT_LIM + 1)))
                                   / (CLK_F >> SHIFT_LIM);
    localparam logic [ACC_W:0] INC_V     = INC[ACC_W:0];
    localparam bit             RATIO_ONE = (CLK_F == RATE);

    logic [ACC_W:0] acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc <= '0;
        else        acc <= {1'b0, acc[ACC_W-1:0]} + INC_V;
    end

    assign tick = RATIO_ONE ? 1'b1 : acc[ACC_W];

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: synchronised, oversampled RxD, 3-sample majority vote per bit,
// byte delivery on a valid/ack handshake with frame-error and overrun flags.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_IDLE  | line idle, waiting for a low sample on a tick
//   ST_START | validating start bit; high vote rejects it as a glitch
//   ST_DATA  | shifting in 8 data bits, LSB first
//   ST_STOP  | voting the stop bit; high delivers, low flags a frame error
//   ST_BREAK | line held low after a bad stop bit; wait for it to go high
module uart_receiver
    import uart_receiver_pkg::*;
#(
    parameter int ClkFrequency = 12000000,
    parameter int Baud         = 115200,
    parameter int Oversampling = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RxD,
    output logic [7:0] RxD_data,
    output logic       RxD_valid,
    input  logic       RxD_ack,
    output logic       RxD_frame_error,
    output logic       RxD_overrun,
    output logic       RxD_busy
);

    if (Oversampling < 4 || Oversampling > 16 || (Oversampling & (Oversampling - 1)) != 0) begin : g_bad_os
        $error("uart_receiver: Oversampling must be a power of 2 in 4..16");
    end

    localparam int SC_W = $clog2(Oversampling);
    localparam logic [SC_W-1:0] IDX_A = SC_W'(Oversampling / 2 - 1);
    localparam logic [SC_W-1:0] IDX_B = SC_W'(Oversampling / 2);
    localparam logic [SC_W-1:0] IDX_V = SC_W'(Oversampling / 2 + 1);

    logic                 tick;
    logic                 rxd_meta, rxd_sync;
    rx_state_e            state, state_nxt;
    logic [SC_W-1:0]      sample_cnt, sample_cnt_nxt, idx;
    logic [2:0]           bit_cnt, bit_cnt_nxt;
    logic [DATA_BITS-1:0] shift, shift_nxt;
    logic                 samp_a, samp_b, vote, at_vote, wrap;
    logic                 deliver, frame_err;

    uart_receiver_os_tick_gen #(
        .ClkFrequency (ClkFrequency),
        .Baud         (Baud),
        .Oversampling (Oversampling)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
        end else begin
            rxd_meta <= RxD;
            rxd_sync <= rxd_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            sample_cnt <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            samp_a     <= 1'b1;
            samp_b     <= 1'b1;
        end else begin
            state      <= state_nxt;
            sample_cnt <= sample_cnt_nxt;
            bit_cnt    <= bit_cnt_nxt;
            shift      <= shift_nxt;
            if (tick && idx == IDX_A) samp_a <= rxd_sync;
            if (tick && idx == IDX_B) samp_b <= rxd_sync;
        end
    end

    // idx is the in-bit position of the current tick; index 0 marks a bit boundary.
    always_comb begin
        state_nxt      = state;
        sample_cnt_nxt = sample_cnt;
        bit_cnt_nxt    = bit_cnt;
        shift_nxt      = shift;
        deliver        = 1'b0;
        frame_err      = 1'b0;
        idx            = sample_cnt + SC_W'(1);
        vote           = (samp_a & samp_b) | (samp_a & rxd_sync) | (samp_b & rxd_sync);
        at_vote        = tick && (idx == IDX_V);
        wrap           = tick && (idx == '0);

        unique case (state)
            ST_IDLE: begin
                if (tick && !rxd_sync) begin
                    state_nxt      = ST_START;
                    sample_cnt_nxt = '0;
                end
            end
            ST_START: begin
                if (tick) sample_cnt_nxt = idx;
                if (at_vote && vote) begin
                    state_nxt = ST_IDLE;
                end else if (wrap) begin
                    state_nxt   = ST_DATA;
                    bit_cnt_nxt = '0;
                end
            end
            ST_DATA: begin
                if (tick)    sample_cnt_nxt = idx;
                if (at_vote) shift_nxt = {vote, shift[DATA_BITS-1:1]};
                if (wrap) begin
                    if (bit_cnt == 3'(DATA_BITS - 1)) state_nxt = ST_STOP;
                    else                              bit_cnt_nxt = bit_cnt + 3'd1;
                end
            end
            ST_STOP: begin
                if (tick) sample_cnt_nxt = idx;
                if (at_vote) begin
                    if (vote) begin
                        deliver   = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        frame_err = 1'b1;
                        state_nxt = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                if (tick && rxd_sync) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RxD_data        <= '0;
            RxD_valid       <= 1'b0;
            RxD_overrun     <= 1'b0;
            RxD_frame_error <= 1'b0;
        end else begin
            RxD_frame_error <= frame_err;
            if (deliver) begin
                if (!RxD_valid) begin
                    RxD_data  <= shift;
                    RxD_valid <= 1'b1;
                end else if (RxD_ack) begin
                    RxD_data    <= shift;
                    RxD_overrun <= 1'b0;
                end else begin
                    RxD_overrun <= 1'b1;
                end
            end else if (RxD_ack && RxD_valid) begin
                RxD_valid   <= 1'b0;
                RxD_overrun <= 1'b0;
            end
        end
    end

    assign RxD_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: serial frames driven in real time at 115200 baud against a
// queue-based model of expected deliveries/errors with timing windows and the handshake.
`timescale 1ns/1ps
module tb_uart_receiver;

    localparam real CLK_HALF = 41.6667;
    localparam real NB       = 1.0e9 / 115200.0;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       RxD     = 1'b1;
    logic       RxD_ack = 1'b0;
    logic [7:0] RxD_data;
    logic       RxD_valid, RxD_frame_error, RxD_overrun, RxD_busy;

    uart_receiver #(
        .ClkFrequency (12000000),
        .Baud         (115200),
        .Oversampling (8)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .RxD             (RxD),
        .RxD_data        (RxD_data),
        .RxD_valid       (RxD_valid),
        .RxD_ack         (RxD_ack),
        .RxD_frame_error (RxD_frame_error),
        .RxD_overrun     (RxD_overrun),
        .RxD_busy        (RxD_busy)
    );

    always #(CLK_HALF) clk = ~clk;

    typedef struct {
        bit         is_err;
        logic [7:0] b;
        real        t_lo;
        real        t_hi;
    } exp_ev_t;

    exp_ev_t    ev_q[$];
    int         n_vec = 0;
    int         n_bad = 0;
    logic       ack_q = 1'b0;
    logic       m_valid = 1'b0;
    logic       m_overrun = 1'b0;
    logic [7:0] m_data = 8'h00;

    task automatic check1(input string nm, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got 0x%h, expected 0x%h", nm, $time, got, exp);
        end
    endtask

    task automatic print_summary;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    endtask

    // Handshake model: a completed byte either loads, replaces (ack same clk) or overruns.
    task automatic deliver_model(input logic [7:0] b);
        if (!m_valid) begin
            m_data  = b;
            m_valid = 1'b1;
        end else if (ack_q) begin
            m_data    = b;
            m_overrun = 1'b0;
        end else begin
            m_overrun = 1'b1;
        end
    endtask

    always @(posedge clk) ack_q <= RxD_ack;

    always @(negedge clk) begin
        real now;
        bit  diff;
        now = $realtime;
        if (!rst_n) begin
            m_valid   = 1'b0;
            m_overrun = 1'b0;
            m_data    = 8'h00;
            ev_q.delete();
        end else begin
            diff = (RxD_valid !== m_valid) || (RxD_data !== m_data) || (RxD_overrun !== m_overrun);
            if (ev_q.size() > 0 && !ev_q[0].is_err && now >= ev_q[0].t_lo &&
                (diff || now > ev_q[0].t_hi)) begin
                deliver_model(ev_q[0].b);
                void'(ev_q.pop_front());
            end else if (ack_q && m_valid) begin
                m_valid   = 1'b0;
                m_overrun = 1'b0;
            end

            if (ev_q.size() > 0 && ev_q[0].is_err && now >= ev_q[0].t_lo && RxD_frame_error) begin
                check1("frame_error_pulse", 8'(RxD_frame_error), 8'd1);
                void'(ev_q.pop_front());
            end else if (ev_q.size() > 0 && ev_q[0].is_err && now > ev_q[0].t_hi) begin
                check1("frame_error_missing", 8'(RxD_frame_error), 8'd1);
                void'(ev_q.pop_front());
            end else begin
                check1("frame_error_idle", 8'(RxD_frame_error), 8'd0);
            end
        end
        check1("cyc_valid", 8'(RxD_valid), 8'(m_valid));
        check1("cyc_data", RxD_data, m_data);
        check1("cyc_overrun", 8'(RxD_overrun), 8'(m_overrun));
    end

    task automatic sync_pt;
        @(posedge clk);
        #20;
    endtask

    task automatic pulse_ack;
        @(posedge clk);
        #10 RxD_ack = 1'b1;
        @(posedge clk);
        #10 RxD_ack = 1'b0;
    endtask

    task automatic wait_bits(input real n);
        #(n * NB);
    endtask

    // Delivery (or error) lands 9.6..9.8 nominal bit-times after the start edge.
    task automatic send_frame(input logic [7:0] b, input bit stop_hi, input real bit_ns);
        exp_ev_t e;
        e.is_err = !stop_hi;
        e.b      = b;
        e.t_lo   = $realtime + 9.5 * NB;
        e.t_hi   = $realtime + 9.9 * NB;
        ev_q.push_back(e);
        RxD = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            RxD = b[i];
            #(bit_ns);
        end
        RxD = stop_hi;
        #(bit_ns);
    endtask

    task automatic frame_and_ack(input logic [7:0] b, input bit stop_hi, input real bit_ns,
                                 input bit do_ack);
        real t0;
        t0 = $realtime;
        send_frame(b, stop_hi, bit_ns);
        if ($realtime < t0 + 10.0 * NB) #(t0 + 10.0 * NB - $realtime);
        sync_pt();
        if (stop_hi) check1("busy_after_stop", 8'(RxD_busy), 8'd0);
        if (do_ack) pulse_ack();
    endtask

    initial begin
        #(7_500_000);
        check1("watchdog", 8'd1, 8'd0);
        print_summary();
        $finish;
    end

    initial begin
        logic [7:0] bytes4 [4];
        logic [7:0] rb, p;
        bit         rstop, rack;
        int         sk;
        real        bn;

        bytes4[0] = 8'h55; bytes4[1] = 8'hAA; bytes4[2] = 8'h00; bytes4[3] = 8'hFF;

        repeat (5) @(posedge clk);
        #10;
        check1("rst_valid", 8'(RxD_valid), 8'd0);
        check1("rst_data", RxD_data, 8'h00);
        check1("rst_overrun", 8'(RxD_overrun), 8'd0);
        check1("rst_ferr", 8'(RxD_frame_error), 8'd0);
        check1("rst_busy", 8'(RxD_busy), 8'd0);
        rst_n = 1'b1;
        wait_bits(2);

        frame_and_ack(8'h21, 1'b1, NB, 1'b0);
        check1("t1_data", RxD_data, 8'h21);
        check1("t1_valid", 8'(RxD_valid), 8'd1);
        check1("t1_overrun", 8'(RxD_overrun), 8'd0);
        pulse_ack();
        sync_pt();
        check1("t1_valid_acked", 8'(RxD_valid), 8'd0);
        wait_bits(1);

        for (int i = 0; i < 4; i++) frame_and_ack(bytes4[i], 1'b1, NB, 1'b1);
        sync_pt();
        check1("t2_last_data", RxD_data, 8'hFF);
        check1("t2_overrun", 8'(RxD_overrun), 8'd0);
        wait_bits(1);

        frame_and_ack(8'h3C, 1'b1, NB, 1'b0);
        frame_and_ack(8'hC3, 1'b1, NB, 1'b0);
        check1("t3_data_kept", RxD_data, 8'h3C);
        check1("t3_valid", 8'(RxD_valid), 8'd1);
        check1("t3_overrun", 8'(RxD_overrun), 8'd1);
        pulse_ack();
        sync_pt();
        check1("t3_valid_acked", 8'(RxD_valid), 8'd0);
        check1("t3_overrun_acked", 8'(RxD_overrun), 8'd0);
        wait_bits(1);

        send_frame(8'h7E, 1'b0, NB);
        wait_bits(3);
        sync_pt();
        check1("t4_busy_break", 8'(RxD_busy), 8'd1);
        RxD = 1'b1;
        wait_bits(2);
        sync_pt();
        check1("t4_busy_idle", 8'(RxD_busy), 8'd0);
        check1("t4_valid", 8'(RxD_valid), 8'd0);
        frame_and_ack(8'h5A, 1'b1, NB, 1'b0);
        check1("t4_data", RxD_data, 8'h5A);
        pulse_ack();
        wait_bits(1);

        RxD = 1'b0;
        #(4.0 * CLK_HALF);
        RxD = 1'b1;
        wait_bits(1);
        sync_pt();
        check1("t5_busy_glitch2clk", 8'(RxD_busy), 8'd0);
        RxD = 1'b0;
        wait_bits(0.3);
        RxD = 1'b1;
        wait_bits(0.7);
        sync_pt();
        check1("t5_busy_glitch03", 8'(RxD_busy), 8'd0);
        check1("t5_valid", 8'(RxD_valid), 8'd0);
        wait_bits(1);

        p = 8'h99;
        RxD = 1'b0;
        wait_bits(1);
        for (int i = 0; i < 4; i++) begin
            RxD = p[i];
            wait_bits(1);
        end
        @(posedge clk);
        #10 rst_n = 1'b0;
        RxD = 1'b1;
        repeat (3) @(posedge clk);
        #10 rst_n = 1'b1;
        sync_pt();
        check1("t6_busy_after_rst", 8'(RxD_busy), 8'd0);
        wait_bits(2);
        frame_and_ack(8'h42, 1'b1, NB, 1'b0);
        check1("t6_data", RxD_data, 8'h42);
        pulse_ack();
        wait_bits(1);
        frame_and_ack(8'hA5, 1'b1, NB * 0.98, 1'b0);
        check1("t6_fast_data", RxD_data, 8'hA5);
        pulse_ack();
        wait_bits(1);
        frame_and_ack(8'hA5, 1'b1, NB * 1.02, 1'b0);
        check1("t6_slow_data", RxD_data, 8'hA5);
        pulse_ack();
        wait_bits(1);

        for (int k = 0; k < 20; k++) begin
            rb    = 8'($urandom);
            rstop = ($urandom_range(0, 5) != 0);
            rack  = ($urandom_range(0, 3) != 0);
            sk    = int'($urandom_range(0, 30));
            bn    = NB * (1.0 + real'(sk - 15) / 1000.0);
            frame_and_ack(rb, rstop, bn, rack);
            if (!rstop) begin
                RxD = 1'b1;
                wait_bits(1);
            end
            wait_bits(real'($urandom_range(0, 3)));
        end

        wait_bits(2);
        sync_pt();
        check1("events_drained", 8'(ev_q.size()), 8'd0);
        print_summary();
        $finish;
    end

endmodule
